stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Sequencing controller for the seven-segment stopwatch datapath. It conditions two raw push-buttons (start/stop and lap/clear), runs the stopwatch state machine, and drives `run` and `reset` of the BCD timer. It also selects live or lap-frozen digits for the display controller and blinks the display while paused. It sits between the board inputs and the existing timer and display blocks in the top level.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable synchronized samples required to accept a button level.
- `BLINK_CYCLES`, default 50_000_000: blink half-period in clocks while paused.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous assert, active-low; internally released synchronously.
- `btn_start`  in  1: raw start/stop button, asynchronous, active-high.
- `btn_lap`  in  1: raw lap/clear button, asynchronous, active-high.
- `digits_in`  in  16: live timer digits, 4×BCD, `[3:0]` = digit0.
- `timer_run`  out  1: timer count enable.
- `timer_clear`  out  1: one-cycle clear pulse to the timer reset.
- `disp_data`  out  16: digits presented to the display controller.
- `disp_enable`  out  4: per-digit enable to the display controller.
- `disp_point`  out  4: decimal points, constant 4'b0100.
- `state_o`  out  2: current state encoding, for LEDs and debug.

## Operation
- Button conditioner, per button:
  - 2-flop synchronizer, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES equal consecutive synchronized samples differ from the current level.
  - Each 0→1 change of the debounced level emits a one-cycle `press` pulse. Releases emit nothing.
- States: IDLE=0, RUN=1, LAP=2, PAUSE=3.
- IDLE: `start` → RUN. `lap` is ignored.
- RUN: `start` → PAUSE. `lap` → LAP and captures `digits_in` into the lap register.
- LAP: the timer keeps running and the display shows the lap register. `lap` → RUN. `start` → PAUSE.
- PAUSE: `start` → RUN. `lap` → IDLE and emits `timer_clear`.
- Simultaneous `start` and `lap` pulses in the same cycle: `start` is taken and `lap` is discarded.
- Outputs, all registered and decoded from the next state:
  - `timer_run` = 1 in RUN and LAP.
  - `disp_data` = lap register in LAP, otherwise `digits_in`, registered.
  - `disp_enable` = 4'b1111, except in PAUSE where it toggles between 4'b1111 and 4'b0000 every BLINK_CYCLES.
- Blink counter:
  - Cleared, with the phase set to "on", on every entry to PAUSE.
  - Free-runs only while in PAUSE and wraps at BLINK_CYCLES-1.
- `timer_clear` is high for exactly one cycle, the first cycle in IDLE after leaving PAUSE.
- Reset mid-operation: all state is lost immediately and the block returns to IDLE. `timer_clear` stays 0 during reset because the timer shares the board reset.

## Timing
- Reset values:
  - `timer_run`=0, `timer_clear`=0, `disp_data`=0, `disp_enable`=4'b1111, `disp_point`=4'b0100, `state_o`=0.
  - Lap register 0, debounced levels 0, all counters 0.
- Press latency: the `press` pulse is high in cycle N+2+DEBOUNCE_CYCLES, where N is the first clock edge sampling the new raw level.
- State, `timer_run` and `timer_clear` update on the edge after the `press` pulse (1 cycle).
- `disp_data` update: 1 cycle after the state edge. The lap capture uses the `digits_in` value present in the `press` cycle.
- Bounce shorter than DEBOUNCE_CYCLES restarts the stability count and produces no pulse.
- Held button: exactly one pulse.
- `disp_enable` first toggles BLINK_CYCLES cycles after PAUSE entry.

## Structure
- Package `stopwatch_pkg`: state enum `sw_state_t` (2-bit, values above), constant `DP_PATTERN = 4'b0100`, BCD digit typedef.
- Sub-module `button_conditioner`: instantiated twice, parameter DEBOUNCE_CYCLES, ports `clk`, `reset_n`, `btn`, `level`, `press`. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Top of block: FSM, lap register, blink counter, output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
- Reset, then idle 20 cycles → all outputs at the reset values above, `state_o`=0.
- `btn_start` high 3 cycles then low (bounce) → no pulse, `timer_run` stays 0. Held 10 cycles → `timer_run`=1 exactly 7 cycles after the first sampling edge, `state_o`=1.
- In RUN with `digits_in`=16'h0123, press `lap` → `state_o`=2, `disp_data`=16'h0123 held while `digits_in` moves to 16'h0150. Second `lap` → `disp_data` follows live digits.
- Press `start` in RUN → `timer_run`=0. `disp_enable` 4'b1111 for 8 cycles, then 4'b0000 for 8, repeating.
- In PAUSE, press `lap` → `timer_clear` high exactly 1 cycle, `state_o`=0, `disp_enable`=4'b1111.
- Both buttons pressed on the same edge in RUN → PAUSE, lap register unchanged. Assert `reset_n` low mid-debounce → outputs return to reset values asynchronously and no pulse follows release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_t;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [3:0] bcd4_t;   // [0] = least significant digit

    localparam logic [3:0] DP_PATTERN = 4'b0100;

endpackage

// File: rtl/button_conditioner.sv
// Synchronizes and debounces one raw push-button, emitting a pulse per accepted press.
// Latency: press pulse is high DEBOUNCE_CYCLES+2 cycles after the first edge sampling a new level.
// Backpressure: none; the pulse is a single cycle and is not held.
//
// Ports: clk, reset_n (async active-low), btn (raw, asynchronous),
//        level (debounced level), press (one-cycle pulse on each 0->1 of level).
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;

    // The counter tracks how many consecutive synchronized samples have
    // disagreed with the accepted level; any agreeing sample restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_sync[1];   // rising only; releases are silent
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button conditioning, run/lap/pause FSM, lap freeze and pause blink.
// Latency: state and timer controls 1 cycle after a press pulse; disp_data 1 cycle after that.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
//
// Ports: clk, reset_n (async assert, sync release), btn_start/btn_lap (raw buttons),
//        digits_in (live BCD), timer_run/timer_clear (to timer), disp_data/disp_enable/
//        disp_point (to display), state_o (current state).
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 50_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start,
    input  logic        btn_lap,
    input  logic [15:0] digits_in,
    output logic        timer_run,
    output logic        timer_clear,
    output logic [15:0] disp_data,
    output logic [3:0]  disp_enable,
    output logic [3:0]  disp_point,
    output logic [1:0]  state_o
);

    localparam int            BW        = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    // Reset asserts immediately but releases on a clock edge, so no flop
    // sees reset removal near its active edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic w_start_press, w_lap_press;
    logic w_unused_start_level, w_unused_lap_level;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk     (clk),
        .reset_n (w_rst_n),
        .btn     (btn_start),
        .level   (w_unused_start_level),
        .press   (w_start_press)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk     (clk),
        .reset_n (w_rst_n),
        .btn     (btn_lap),
        .level   (w_unused_lap_level),
        .press   (w_lap_press)
    );

    sw_state_t     r_state, w_next;
    bcd4_t         r_lap;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic          r_blink_on,  w_blink_on_nxt;
    logic          r_timer_run, r_timer_clear;
    logic [15:0]   r_disp_data;
    logic [3:0]    r_disp_enable;

    // Start has priority: a lap pulse coinciding with start is dropped.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_press) w_next = ST_RUN;
            ST_RUN:   if (w_start_press) w_next = ST_PAUSE;
                      else if (w_lap_press) w_next = ST_LAP;
            ST_LAP:   if (w_start_press) w_next = ST_PAUSE;
                      else if (w_lap_press) w_next = ST_RUN;
            ST_PAUSE: if (w_start_press) w_next = ST_RUN;
                      else if (w_lap_press) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Blink phase restarts "on" at every PAUSE entry and only advances
    // while staying in PAUSE.
    always_comb begin
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        if (w_next == ST_PAUSE && r_state != ST_PAUSE) begin
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = 1'b1;
        end else if (w_next == ST_PAUSE) begin
            if (r_blink_cnt == BLINK_MAX) begin
                w_blink_cnt_nxt = '0;
                w_blink_on_nxt  = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state       <= ST_IDLE;
            r_lap         <= '0;
            r_blink_cnt   <= '0;
            r_blink_on    <= 1'b1;
            r_timer_run   <= 1'b0;
            r_timer_clear <= 1'b0;
            r_disp_data   <= '0;
            r_disp_enable <= 4'b1111;
        end else begin
            r_state       <= w_next;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_on    <= w_blink_on_nxt;
            r_timer_run   <= (w_next == ST_RUN) || (w_next == ST_LAP);
            r_timer_clear <= (r_state == ST_PAUSE) && (w_next == ST_IDLE);
            r_disp_enable <= (w_next == ST_PAUSE && !w_blink_on_nxt) ? 4'b0000 : 4'b1111;
            // Lap register is loaded on the same edge the state enters LAP,
            // so the display switches to it one cycle later.
            r_disp_data   <= (r_state == ST_LAP) ? r_lap : digits_in;
            if (r_state == ST_RUN && w_next == ST_LAP)
                r_lap <= digits_in;
        end
    end

    assign timer_run   = r_timer_run;
    assign timer_clear = r_timer_clear;
    assign disp_data   = r_disp_data;
    assign disp_enable = r_disp_enable;
    assign disp_point  = DP_PATTERN;
    assign state_o     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int F_STATE = 0, F_RUN = 1, F_CLEAR = 2, F_DATA = 3, F_EN = 4, F_POINT = 5;

    logic        clk = 1'b0;
    logic        reset_n, btn_start, btn_lap;
    logic [15:0] digits_in;
    logic        timer_run, timer_clear;
    logic [15:0] disp_data;
    logic [3:0]  disp_enable, disp_point;
    logic [1:0]  state_o;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .digits_in   (digits_in),
        .timer_run   (timer_run),
        .timer_clear (timer_clear),
        .disp_data   (disp_data),
        .disp_enable (disp_enable),
        .disp_point  (disp_point),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        int          f;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic exp_push(input int c, input int f, input logic [15:0] v);
        exp_t e;
        e.c = c;
        e.f = f;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic exp_reset_vals(input int c);
        exp_push(c, F_STATE, 16'h0);
        exp_push(c, F_RUN,   16'h0);
        exp_push(c, F_CLEAR, 16'h0);
        exp_push(c, F_DATA,  16'h0);
        exp_push(c, F_EN,    16'h000F);
        exp_push(c, F_POINT, 16'h0004);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] actual(input int f);
        case (f)
            F_STATE: return {14'b0, state_o};
            F_RUN:   return {15'b0, timer_run};
            F_CLEAR: return {15'b0, timer_clear};
            F_DATA:  return disp_data;
            F_EN:    return {12'b0, disp_enable};
            default: return {12'b0, disp_point};
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_STATE: return "state_o";
            F_RUN:   return "timer_run";
            F_CLEAR: return "timer_clear";
            F_DATA:  return "disp_data";
            F_EN:    return "disp_enable";
            default: return "disp_point";
        endcase
    endfunction

    // Monitor: every falling edge, compare outputs against all entries due this cycle.
    always @(negedge clk) begin
        logic [15:0] a;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].c == cyc) begin
                a = actual(sb[i].f);
                n_cmp++;
                if (a !== sb[i].v) begin
                    n_err++;
                    $display("FAIL %s cycle %0d: actual %h required %h", fname(sb[i].f), cyc, a, sb[i].v);
                end
                sb.delete(i);
            end else if (sb[i].c < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s cycle %0d: never sampled, required %h", fname(sb[i].f), sb[i].c, sb[i].v);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n   = 1'b0;
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        digits_in = 16'h0000;

        // Reset values during and after reset
        step(3);
        exp_reset_vals(cyc);
        step(1);
        reset_n = 1'b1;
        step(20);
        exp_reset_vals(cyc);
        step(1);

        // Bounce: 3 cycles high is too short
        t = cyc;
        btn_start = 1'b1;
        exp_push(t + 8,  F_RUN,   16'h0);
        exp_push(t + 12, F_STATE, 16'h0);
        step(3);
        btn_start = 1'b0;
        step(14);

        // Held start: timer_run rises 7 cycles after the first sampling edge
        t = cyc;
        btn_start = 1'b1;
        exp_push(t + 7, F_RUN,   16'h0);
        exp_push(t + 8, F_RUN,   16'h1);
        exp_push(t + 8, F_STATE, 16'h1);
        step(10);
        btn_start = 1'b0;
        step(10);

        // Lap capture and freeze
        digits_in = 16'h0123;
        step(2);
        t = cyc;
        btn_lap = 1'b1;
        exp_push(t + 7, F_STATE, 16'h1);
        exp_push(t + 8, F_STATE, 16'h2);
        exp_push(t + 8, F_RUN,   16'h1);
        exp_push(t + 9, F_DATA,  16'h0123);
        exp_push(t + 12, F_DATA, 16'h0123);
        step(8);
        digits_in = 16'h0150;
        step(2);
        btn_lap = 1'b0;
        step(10);

        // Second lap: back to live digits
        t = cyc;
        btn_lap = 1'b1;
        exp_push(t + 8, F_STATE, 16'h1);
        exp_push(t + 8, F_DATA,  16'h0123);
        exp_push(t + 9, F_DATA,  16'h0150);
        step(10);
        btn_lap = 1'b0;
        step(10);

        // Pause and blink
        t = cyc;
        btn_start = 1'b1;
        exp_push(t + 8,  F_STATE, 16'h3);
        exp_push(t + 8,  F_RUN,   16'h0);
        exp_push(t + 8,  F_EN,    16'h000F);
        exp_push(t + 15, F_EN,    16'h000F);
        exp_push(t + 16, F_EN,    16'h0000);
        exp_push(t + 20, F_DATA,  16'h0150);
        exp_push(t + 23, F_EN,    16'h0000);
        exp_push(t + 24, F_EN,    16'h000F);
        exp_push(t + 31, F_EN,    16'h000F);
        exp_push(t + 32, F_EN,    16'h0000);
        step(10);
        btn_start = 1'b0;
        step(24);

        // Lap in pause: clear pulse and back to idle
        t = cyc;
        btn_lap = 1'b1;
        exp_push(t + 7, F_CLEAR, 16'h0);
        exp_push(t + 8, F_CLEAR, 16'h1);
        exp_push(t + 8, F_STATE, 16'h0);
        exp_push(t + 8, F_EN,    16'h000F);
        exp_push(t + 9, F_CLEAR, 16'h0);
        exp_push(t + 9, F_RUN,   16'h0);
        step(10);
        btn_lap = 1'b0;
        step(10);

        // Back to RUN
        t = cyc;
        btn_start = 1'b1;
        exp_push(t + 8, F_STATE, 16'h1);
        step(10);
        btn_start = 1'b0;
        step(10);

        // Both buttons together: start wins
        digits_in = 16'h0999;
        step(1);
        t = cyc;
        btn_start = 1'b1;
        btn_lap   = 1'b1;
        exp_push(t + 8,  F_STATE, 16'h3);
        exp_push(t + 8,  F_RUN,   16'h0);
        exp_push(t + 10, F_DATA,  16'h0999);
        exp_push(t + 16, F_EN,    16'h0000);
        exp_push(t + 18, F_STATE, 16'h3);
        step(10);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        step(10);

        // Reset in the middle of a debounce
        btn_start = 1'b1;
        step(3);
        reset_n = 1'b0;
        exp_reset_vals(cyc);
        btn_start = 1'b0;
        step(3);
        reset_n = 1'b1;
        t = cyc;
        exp_push(t + 12, F_STATE, 16'h0);
        exp_push(t + 12, F_RUN,   16'h0);
        exp_push(t + 12, F_DATA,  16'h0999);
        step(15);

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
